decryption_scheduler: RTL and testbench
=======================================

# decryption_scheduler

Front-end controller that shares one upstream ciphertext stream between three decryption engines (index 0 Caesar, 1 Scytale, 2 Zigzag). It latches a per-message engine select, holds the engine keys and forwards them, steers each input beat to the chosen engine, and muxes the chosen engine's plaintext back onto one output port. It sits between the byte source and the engine bank and owns the single upstream `busy_o` back-pressure signal.

## Interface
- D_WIDTH, 8, data byte width
- KEY_WIDTH, 8, width of every key field
- MAX_NOF_CHARS, 50, max ciphertext beats per message, token excluded
- START_DECRYPTION_TOKEN, 8'hFA, end-of-message marker, forwarded to the engine
- TIMEOUT, 4, cycles allowed for an engine to raise busy after the token
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-high reset (despite the name)
- data_i  in  D_WIDTH  ciphertext byte
- valid_i  in  1  data_i qualifier
- sel_i  in  2  engine select, sampled on the first beat of a message only
- cfg_we_i  in  1  key write strobe
- cfg_addr_i  in  2  0 caesar_key, 1 key_N, 2 key_M, 3 zigzag_key
- cfg_data_i  in  KEY_WIDTH  key value
- eng_data_o  out  D_WIDTH  shared byte bus to all engines
- eng_valid_o  out  3  one-hot beat strobe per engine
- caesar_key_o, key_N_o, key_M_o, zigzag_key_o  out  KEY_WIDTH each  held key registers
- eng_busy_i  in  3  busy from each engine
- eng_data0_i, eng_data1_i, eng_data2_i  in  D_WIDTH  engine plaintext
- eng_valid_i  in  3  engine output valid
- data_o  out  D_WIDTH  muxed plaintext
- valid_o  out  1  data_o qualifier
- busy_o  out  1  upstream must not drive valid_i while high
- err_o  out  1  one-cycle pulse: overflow, bad select, timeout or config write rejected

## Operation
- Reset: all outputs 0, key registers 0, FSM IDLE, beat count 0.
- Config: a write with `cfg_we_i` high in IDLE updates the addressed key register next cycle. In any other state the write is dropped and `err_o` pulses.
- FSM states: IDLE, FORWARD, WAIT_ENG, DRAIN, FLUSH.
- IDLE, valid_i beat arrives:
  - sel_i = 3: go to FLUSH, pulse `err_o`, drop the beat.
  - Otherwise latch `act_sel = sel_i` and forward the beat.
  - If that beat is the token, go to WAIT_ENG. Otherwise go to FORWARD with count = 1.
- FORWARD: each valid_i beat is forwarded to `act_sel`.
  - Token: forward it and go to WAIT_ENG.
  - Non-token beat while count == MAX_NOF_CHARS: drop it and pulse `err_o`. Stay in FORWARD until the token.
  - Otherwise count++. Count width is clog2(MAX_NOF_CHARS+1).
- WAIT_ENG: `eng_busy_i[act_sel]` high → DRAIN. After TIMEOUT cycles with it still low → pulse `err_o` and go to IDLE.
- DRAIN: on `eng_valid_i[act_sel]`, present that engine's data on `data_o` with `valid_o`. When `eng_busy_i[act_sel]` falls, go to IDLE and clear the count.
- FLUSH: drop all beats. The token returns the FSM to IDLE; the token itself is not forwarded.
- Outputs of non-selected engines are ignored at all times. Non-selected `eng_valid_o` bits are always 0.
- Byte value 0 is ordinary data; only the token ends a message.

## Timing
- Forward path is registered. A beat on valid_i at cycle t appears on `eng_data_o` and `eng_valid_o[act_sel]` at t+1.
- Return path is registered. `eng_valid_i` at cycle t appears on `valid_o` and `data_o` at t+1. `data_o` is 0 whenever `valid_o` is 0.
- `busy_o` is registered:
  - It is 1 from the cycle after the token is accepted until the cycle after the return to IDLE.
  - It is 0 in IDLE and FORWARD.
  - It is 1 in FLUSH, but beats are still consumed so the token can be seen.
- valid_i while `busy_o` is high in WAIT_ENG or DRAIN: beat dropped, `err_o` pulse.
- Simultaneous `cfg_we_i` and the first valid_i beat in IDLE: the config write takes effect and the beat is accepted. The new key is visible on the key outputs at the same edge as the forwarded beat.
- Reset asserted mid-message: on the next edge all outputs, registers and FSM return to reset values. Engines see `eng_valid_o` = 0 from that edge.
- `err_o` pulses are exactly one cycle. Multiple error causes in one cycle give one pulse.

## Test plan
- Caesar message: write caesar_key=3, sel=0, beats 'D','E','F', token, engine returns 'A','B','C' → data_o A,B,C each 1 cycle after engine valid; busy_o falls after engine busy; count cleared.
- Scytale config and routing: write key_N=2, key_M=3, sel=1, 6 beats + token → only eng_valid_o[1] toggles, key_N_o=2, key_M_o=3, eng_data_o mirrors input with 1-cycle lag.
- Overflow: MAX_NOF_CHARS=4, send 6 bytes + token → 4 forwarded, 2 err_o pulses, token forwarded, FSM reaches WAIT_ENG.
- Bad select and config lock: sel=3 with 3 beats + token → nothing forwarded, one err_o, back to IDLE. cfg write during DRAIN → key unchanged, err_o pulse.
- Timeout: token sent, engine never raises busy → err_o exactly TIMEOUT cycles after WAIT_ENG entry, busy_o low next cycle.
- Mid-message reset: rst_n high during FORWARD → next cycle all outputs 0, keys 0; a following sel=2 message routes cleanly to engine 2.

Source files
------------

// File: rtl/decryption_scheduler.sv
// Front-end controller sharing one ciphertext stream between three decryption engines:
// latches the per-message engine select, holds the keys and muxes the chosen engine's plaintext back.
module decryption_scheduler #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 TIMEOUT                = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [1:0]           sel_i,
  input  logic                 cfg_we_i,
  input  logic [1:0]           cfg_addr_i,
  input  logic [KEY_WIDTH-1:0] cfg_data_i,
  output logic [D_WIDTH-1:0]   eng_data_o,
  output logic [2:0]           eng_valid_o,
  output logic [KEY_WIDTH-1:0] caesar_key_o,
  output logic [KEY_WIDTH-1:0] key_N_o,
  output logic [KEY_WIDTH-1:0] key_M_o,
  output logic [KEY_WIDTH-1:0] zigzag_key_o,
  input  logic [2:0]           eng_busy_i,
  input  logic [D_WIDTH-1:0]   eng_data0_i,
  input  logic [D_WIDTH-1:0]   eng_data1_i,
  input  logic [D_WIDTH-1:0]   eng_data2_i,
  input  logic [2:0]           eng_valid_i,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_NOF_CHARS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(32'd1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FORWARD  = 3'd1,
    WAIT_ENG = 3'd2,
    DRAIN    = 3'd3,
    FLUSH    = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [1:0]         act_sel_r, act_sel_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [TMR_W-1:0]   timer_r, timer_s;
  logic               fwd_s;
  logic [1:0]         fwd_sel_s;
  logic               fsm_err_s;
  logic               is_tok_s;
  logic [3:0]         busy_pad_s;
  logic [3:0]         valid_pad_s;
  logic               sel_busy_s;
  logic               ret_valid_s;
  logic [D_WIDTH-1:0] ret_data_s;
  logic               cfg_ok_s;
  logic               cfg_rej_s;
  logic               busy_next_s;

  assign is_tok_s    = (data_i == START_DECRYPTION_TOKEN);
  // Padding to four entries keeps the 2-bit select in range; select 3 never becomes active.
  assign busy_pad_s  = {1'b0, eng_busy_i};
  assign valid_pad_s = {1'b0, eng_valid_i};
  assign sel_busy_s  = busy_pad_s[act_sel_r];
  assign ret_valid_s = (state_r == DRAIN) && valid_pad_s[act_sel_r];
  assign cfg_ok_s    = cfg_we_i && (state_r == IDLE);
  assign cfg_rej_s   = cfg_we_i && (state_r != IDLE);
  assign busy_next_s = (state_s == WAIT_ENG) || (state_s == DRAIN) || (state_s == FLUSH);

  // Next-state, beat steering and FSM-side error detection
  always_comb begin
    state_s   = state_r;
    act_sel_s = act_sel_r;
    count_s   = count_r;
    timer_s   = timer_r;
    fwd_s     = 1'b0;
    fwd_sel_s = act_sel_r;
    fsm_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        timer_s = '0;
        if (valid_i) begin
          if (sel_i == 2'd3) begin
            fsm_err_s = 1'b1;
            // A bad-select token already closes its own message, so nothing is left to flush.
            state_s   = is_tok_s ? IDLE : FLUSH;
          end else begin
            act_sel_s = sel_i;
            fwd_sel_s = sel_i;
            fwd_s     = 1'b1;
            state_s   = is_tok_s ? WAIT_ENG : FORWARD;
            count_s   = is_tok_s ? '0 : CNT_ONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FORWARD: begin
        if (valid_i) begin
          if (is_tok_s) begin
            fwd_s   = 1'b1;
            state_s = WAIT_ENG;
          end else if (count_r == CNT_MAX) begin
            fsm_err_s = 1'b1;
          end else begin
            fwd_s   = 1'b1;
            count_s = count_r + CNT_ONE;
          end
        end else begin
          state_s = FORWARD;
        end
      end
      WAIT_ENG: begin
        fsm_err_s = valid_i;
        if (sel_busy_s) begin
          state_s = DRAIN;
        end else if (timer_r == TMR_LAST) begin
          fsm_err_s = 1'b1;
          state_s   = IDLE;
          count_s   = '0;
        end else begin
          timer_s = timer_r + TMR_ONE;
        end
      end
      DRAIN: begin
        fsm_err_s = valid_i;
        if (!sel_busy_s) begin
          state_s = IDLE;
          count_s = '0;
        end else begin
          state_s = DRAIN;
        end
      end
      FLUSH: begin
        if (valid_i && is_tok_s) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Plaintext mux over the active engine
  always_comb begin
    case (act_sel_r)
      2'd0:    ret_data_s = eng_data0_i;
      2'd1:    ret_data_s = eng_data1_i;
      2'd2:    ret_data_s = eng_data2_i;
      default: ret_data_s = '0;
    endcase
  end

  // FSM registers and registered forward/return/status outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r     <= IDLE;
      act_sel_r   <= 2'd0;
      count_r     <= '0;
      timer_r     <= '0;
      eng_data_o  <= '0;
      eng_valid_o <= 3'b000;
      data_o      <= '0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_r     <= state_s;
      act_sel_r   <= act_sel_s;
      count_r     <= count_s;
      timer_r     <= timer_s;
      eng_data_o  <= fwd_s ? data_i : '0;
      eng_valid_o <= fwd_s ? (3'b001 << fwd_sel_s) : 3'b000;
      data_o      <= ret_valid_s ? ret_data_s : '0;
      valid_o     <= ret_valid_s;
      busy_o      <= busy_next_s;
      err_o       <= fsm_err_s | cfg_rej_s;
    end
  end

  // Key registers, writable only between messages
  always_ff @(posedge clk) begin
    if (rst_n) begin
      caesar_key_o <= '0;
      key_N_o      <= '0;
      key_M_o      <= '0;
      zigzag_key_o <= '0;
    end else if (cfg_ok_s) begin
      case (cfg_addr_i)
        2'd0:    caesar_key_o <= cfg_data_i;
        2'd1:    key_N_o      <= cfg_data_i;
        2'd2:    key_M_o      <= cfg_data_i;
        2'd3:    zigzag_key_o <= cfg_data_i;
        default: caesar_key_o <= caesar_key_o;
      endcase
    end else begin
      caesar_key_o <= caesar_key_o;
    end
  end

endmodule

// File: tb/tb_decryption_scheduler.sv
// Directed bench for decryption_scheduler: a cycle-by-cycle vector table plus hand-written
// sequences for overflow (second instance with MAX_NOF_CHARS=4), timeout and mid-message reset.
module tb_decryption_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, valid_i, cfg_we_i;
  logic [7:0] data_i, cfg_data_i, eng_data0_i, eng_data1_i, eng_data2_i;
  logic [1:0] sel_i, cfg_addr_i;
  logic [2:0] eng_busy_i, eng_valid_i;

  logic [7:0] eng_data_o, caesar_key_o, key_N_o, key_M_o, zigzag_key_o, data_o;
  logic [2:0] eng_valid_o;
  logic       valid_o, busy_o, err_o;

  logic [7:0] o_eng_data, o_ck, o_kn, o_km, o_kz, o_data;
  logic [2:0] o_eng_valid;
  logic       o_valid, o_busy, o_err;

  decryption_scheduler dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .sel_i(sel_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o),
    .caesar_key_o(caesar_key_o), .key_N_o(key_N_o), .key_M_o(key_M_o), .zigzag_key_o(zigzag_key_o),
    .eng_busy_i(eng_busy_i), .eng_data0_i(eng_data0_i), .eng_data1_i(eng_data1_i),
    .eng_data2_i(eng_data2_i), .eng_valid_i(eng_valid_i),
    .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o), .err_o(err_o)
  );

  decryption_scheduler #(.MAX_NOF_CHARS(4)) dut_ov (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .sel_i(sel_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .eng_data_o(o_eng_data), .eng_valid_o(o_eng_valid),
    .caesar_key_o(o_ck), .key_N_o(o_kn), .key_M_o(o_km), .zigzag_key_o(o_kz),
    .eng_busy_i(eng_busy_i), .eng_data0_i(eng_data0_i), .eng_data1_i(eng_data1_i),
    .eng_data2_i(eng_data2_i), .eng_valid_i(eng_valid_i),
    .data_o(o_data), .valid_o(o_valid), .busy_o(o_busy), .err_o(o_err)
  );

  typedef struct {
    logic r; logic vld; logic [7:0] d; logic [1:0] sel;
    logic we; logic [1:0] a; logic [7:0] cd;
    logic [2:0] eb; logic [2:0] ev; logic [7:0] ed;
    logic [7:0] eed; logic [2:0] eev; logic [7:0] edo; logic evo;
    logic ebusy; logic eerr; logic [31:0] ekeys;
  } vec_t;

  localparam logic [31:0] K0 = 32'h00000000;
  localparam logic [31:0] K1 = 32'h03000000;
  localparam logic [31:0] K2 = 32'h03020000;
  localparam logic [31:0] K3 = 32'h03020300;
  localparam logic [31:0] K4 = 32'h03020307;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic vld, logic [7:0] d, logic [1:0] sel,
                              logic we, logic [1:0] a, logic [7:0] cd,
                              logic [2:0] eb, logic [2:0] ev, logic [7:0] ed,
                              logic [7:0] eed, logic [2:0] eev, logic [7:0] edo, logic evo,
                              logic ebusy, logic eerr, logic [31:0] ekeys);
    vec_t v;
    v.r = r; v.vld = vld; v.d = d; v.sel = sel; v.we = we; v.a = a; v.cd = cd;
    v.eb = eb; v.ev = ev; v.ed = ed; v.eed = eed; v.eev = eev; v.edo = edo; v.evo = evo;
    v.ebusy = ebusy; v.eerr = eerr; v.ekeys = ekeys;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engines present distinct bytes so a wrong return mux shows up.
  task automatic drv(input logic r, input logic vld, input logic [7:0] d, input logic [1:0] sel,
                     input logic [2:0] eb, input logic [2:0] ev, input logic [7:0] ed);
    rst_n = r; valid_i = vld; data_i = d; sel_i = sel;
    cfg_we_i = 1'b0; cfg_addr_i = 2'd0; cfg_data_i = 8'h00;
    eng_busy_i = eb; eng_valid_i = ev;
    eng_data0_i = ed; eng_data1_i = ed + 8'd1; eng_data2_i = ed + 8'd2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    logic found;
    //          r vld d      sel we a     cd     eb      ev      ed      eed    eev     edo    evo busy err keys
    tbl.push_back(mk(1,0,8'h00,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,0,0,K0));
    tbl.push_back(mk(0,0,8'h00,2'd0,1,2'd0,8'h03,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,0,0,K1));
    tbl.push_back(mk(0,1,8'h44,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h44,3'b001,8'h00,0,0,0,K1));
    tbl.push_back(mk(0,1,8'h45,2'd2,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h45,3'b001,8'h00,0,0,0,K1));
    tbl.push_back(mk(0,1,8'h46,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h46,3'b001,8'h00,0,0,0,K1));
    tbl.push_back(mk(0,1,8'hFA,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'hFA,3'b001,8'h00,0,1,0,K1));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,1,0,K1));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b001,3'b000,8'h00, 8'h00,3'b000,8'h00,0,1,0,K1));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b001,3'b001,8'h41, 8'h00,3'b000,8'h41,1,1,0,K1));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b001,3'b011,8'h42, 8'h00,3'b000,8'h42,1,1,0,K1));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b001,3'b110,8'h99, 8'h00,3'b000,8'h00,0,1,0,K1));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b001,3'b001,8'h43, 8'h00,3'b000,8'h43,1,1,0,K1));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,0,0,K1));
    tbl.push_back(mk(0,0,8'h00,2'd0,1,2'd1,8'h02,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,0,0,K2));
    tbl.push_back(mk(0,0,8'h00,2'd0,1,2'd2,8'h03,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,0,0,K3));
    tbl.push_back(mk(0,1,8'h00,2'd1,1,2'd3,8'h07,3'b000,3'b000,8'h00, 8'h00,3'b010,8'h00,0,0,0,K4));
    tbl.push_back(mk(0,1,8'h11,2'd1,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h11,3'b010,8'h00,0,0,0,K4));
    tbl.push_back(mk(0,1,8'h22,2'd1,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h22,3'b010,8'h00,0,0,0,K4));
    tbl.push_back(mk(0,1,8'h33,2'd1,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h33,3'b010,8'h00,0,0,0,K4));
    tbl.push_back(mk(0,1,8'h44,2'd1,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h44,3'b010,8'h00,0,0,0,K4));
    tbl.push_back(mk(0,1,8'h55,2'd1,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h55,3'b010,8'h00,0,0,0,K4));
    tbl.push_back(mk(0,1,8'hFA,2'd1,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'hFA,3'b010,8'h00,0,1,0,K4));
    tbl.push_back(mk(0,1,8'h66,2'd1,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,1,1,K4));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b010,3'b000,8'h00, 8'h00,3'b000,8'h00,0,1,0,K4));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b010,3'b010,8'h10, 8'h00,3'b000,8'h11,1,1,0,K4));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,0,0,K4));
    tbl.push_back(mk(0,1,8'h31,2'd3,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,1,1,K4));
    tbl.push_back(mk(0,1,8'h32,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,1,0,K4));
    tbl.push_back(mk(0,1,8'h33,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,1,0,K4));
    tbl.push_back(mk(0,1,8'hFA,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,0,0,K4));
    tbl.push_back(mk(0,1,8'h77,2'd2,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h77,3'b100,8'h00,0,0,0,K4));
    tbl.push_back(mk(0,1,8'hFA,2'd2,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'hFA,3'b100,8'h00,0,1,0,K4));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b100,3'b000,8'h00, 8'h00,3'b000,8'h00,0,1,0,K4));
    tbl.push_back(mk(0,0,8'h00,2'd0,1,2'd0,8'h09,3'b100,3'b000,8'h00, 8'h00,3'b000,8'h00,0,1,1,K4));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b000,3'b000,8'h00, 8'h00,3'b000,8'h00,0,0,0,K4));
    tbl.push_back(mk(0,0,8'h00,2'd0,0,2'd0,8'h00,3'b000,3'b100,8'h05, 8'h00,3'b000,8'h00,0,0,0,K4));

    foreach (tbl[i]) begin
      drv(tbl[i].r, tbl[i].vld, tbl[i].d, tbl[i].sel, tbl[i].eb, tbl[i].ev, tbl[i].ed);
      cfg_we_i = tbl[i].we; cfg_addr_i = tbl[i].a; cfg_data_i = tbl[i].cd;
      step();
      chk($sformatf("v%0d_eng_valid", i), {29'd0, eng_valid_o}, {29'd0, tbl[i].eev});
      if (tbl[i].eev != 3'b000) chk($sformatf("v%0d_eng_data", i), {24'd0, eng_data_o}, {24'd0, tbl[i].eed});
      chk($sformatf("v%0d_valid_o", i), {31'd0, valid_o}, {31'd0, tbl[i].evo});
      chk($sformatf("v%0d_data_o", i), {24'd0, data_o}, {24'd0, tbl[i].edo});
      chk($sformatf("v%0d_busy_o", i), {31'd0, busy_o}, {31'd0, tbl[i].ebusy});
      chk($sformatf("v%0d_err_o", i), {31'd0, err_o}, {31'd0, tbl[i].eerr});
      chk($sformatf("v%0d_keys", i), {caesar_key_o, key_N_o, key_M_o, zigzag_key_o}, tbl[i].ekeys);
    end

    // Overflow on the 4-beat instance: beats 5 and 6 dropped with separate err pulses
    for (int i = 1; i <= 4; i++) begin
      drv(1'b0, 1'b1, 8'(i), 2'd0, 3'b000, 3'b000, 8'h00);
      step();
      chk("ov_fwd_valid", {29'd0, o_eng_valid}, 32'd1);
      chk("ov_fwd_data", {24'd0, o_eng_data}, 32'(i));
      chk("ov_fwd_err", {31'd0, o_err}, 32'd0);
    end
    drv(1'b0, 1'b1, 8'h05, 2'd0, 3'b000, 3'b000, 8'h00); step();
    chk("ov_drop5_valid", {29'd0, o_eng_valid}, 32'd0);
    chk("ov_drop5_err", {31'd0, o_err}, 32'd1);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 3'b000, 3'b000, 8'h00); step();
    chk("ov_gap_err", {31'd0, o_err}, 32'd0);
    drv(1'b0, 1'b1, 8'h06, 2'd0, 3'b000, 3'b000, 8'h00); step();
    chk("ov_drop6_valid", {29'd0, o_eng_valid}, 32'd0);
    chk("ov_drop6_err", {31'd0, o_err}, 32'd1);
    drv(1'b0, 1'b1, 8'hFA, 2'd0, 3'b000, 3'b000, 8'h00); step();
    chk("ov_tok_valid", {29'd0, o_eng_valid}, 32'd1);
    chk("ov_tok_data", {24'd0, o_eng_data}, 32'hFA);
    chk("ov_tok_err", {31'd0, o_err}, 32'd0);
    chk("ov_wait_busy", {31'd0, o_busy}, 32'd1);
    chk("ov_main_tok_busy", {31'd0, busy_o}, 32'd1);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 3'b001, 3'b000, 8'h00); step();
    drv(1'b0, 1'b0, 8'h00, 2'd0, 3'b000, 3'b000, 8'h00); step();
    chk("ov_idle_busy", {31'd0, o_busy}, 32'd0);
    chk("ov_idle_valid", {31'd0, o_valid}, 32'd0);
    chk("ov_idle_data", {24'd0, o_data}, 32'd0);
    chk("ov_keys", {o_ck, o_kn, o_km, o_kz}, K4);
    chk("ov_main_idle_busy", {31'd0, busy_o}, 32'd0);

    // Timeout: engine never raises busy after a lone token
    drv(1'b0, 1'b1, 8'hFA, 2'd0, 3'b000, 3'b000, 8'h00); step();
    chk("to_tok_valid", {29'd0, eng_valid_o}, 32'd1);
    chk("to_tok_busy", {31'd0, busy_o}, 32'd1);
    k = 0;
    found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      drv(1'b0, 1'b0, 8'h00, 2'd0, 3'b000, 3'b000, 8'h00); step();
      if (err_o) begin
        found = 1'b1;
        k = i;
      end else begin
        chk("to_wait_busy", {31'd0, busy_o}, 32'd1);
      end
    end
    chk("to_err_latency", 32'(k), 32'd4);
    step();
    chk("to_after_busy", {31'd0, busy_o}, 32'd0);
    chk("to_after_err", {31'd0, err_o}, 32'd0);

    // Reset in the middle of a message, then a clean message to engine 2
    drv(1'b0, 1'b1, 8'h61, 2'd1, 3'b000, 3'b000, 8'h00); step();
    chk("rst_pre_valid", {29'd0, eng_valid_o}, 32'd2);
    drv(1'b1, 1'b1, 8'h62, 2'd1, 3'b000, 3'b000, 8'h00); step();
    chk("rst_eng_valid", {29'd0, eng_valid_o}, 32'd0);
    chk("rst_eng_data", {24'd0, eng_data_o}, 32'd0);
    chk("rst_keys", {caesar_key_o, key_N_o, key_M_o, zigzag_key_o}, K0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    drv(1'b0, 1'b1, 8'h5A, 2'd2, 3'b000, 3'b000, 8'h00); step();
    chk("post_rst_valid", {29'd0, eng_valid_o}, 32'd4);
    chk("post_rst_data", {24'd0, eng_data_o}, 32'h5A);
    drv(1'b0, 1'b1, 8'hFA, 2'd2, 3'b000, 3'b000, 8'h00); step();
    chk("post_rst_tok", {29'd0, eng_valid_o}, 32'd4);
    chk("post_rst_busy", {31'd0, busy_o}, 32'd1);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 3'b100, 3'b000, 8'h00); step();
    drv(1'b0, 1'b0, 8'h00, 2'd0, 3'b100, 3'b111, 8'h20); step();
    chk("post_rst_ret_valid", {31'd0, valid_o}, 32'd1);
    chk("post_rst_ret_data", {24'd0, data_o}, 32'h22);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 3'b000, 3'b000, 8'h00); step();
    chk("post_rst_end_busy", {31'd0, busy_o}, 32'd0);
    chk("post_rst_end_valid", {31'd0, valid_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
